// File: rtl/uart_baud_gen_prog.sv
// Programmable fractional baud-rate generator: oversample tick, bit tick and legacy B_clk,
// with shadowed divisor reload at period boundaries and start-bit phase resync.
module uart_baud_gen_prog #(
  parameter int unsigned CLK_RATE         = 10_000_000,
  parameter int unsigned DEFAULT_BAUD     = 9600,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DIV_WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH       = 4,
  parameter int unsigned DEFAULT_DIV_INT  = CLK_RATE / (DEFAULT_BAUD * OVERSAMPLE),
  parameter int unsigned DEFAULT_DIV_FRAC =
    32'(((64'(CLK_RATE) << FRAC_WIDTH) / 64'(DEFAULT_BAUD * OVERSAMPLE)) % (64'(1) << FRAC_WIDTH))
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DIV_WIDTH-1:0]  div_int,
  input  logic [FRAC_WIDTH-1:0] div_frac,
  input  logic                  div_load,
  input  logic                  sync,
  output logic                  os_tick,
  output logic                  bit_tick,
  output logic                  B_clk,
  output logic                  div_pending
);

  localparam int unsigned CNT_W = DIV_WIDTH + 1;
  localparam int unsigned OS_W  = $clog2(OVERSAMPLE);

  logic [CNT_W-1:0]      cnt, cnt_n;
  logic [DIV_WIDTH-1:0]  active_int, active_int_n, shadow_int, shadow_int_n;
  logic [FRAC_WIDTH-1:0] active_frac, active_frac_n, shadow_frac, shadow_frac_n;
  logic [FRAC_WIDTH-1:0] frac_acc, frac_acc_n;
  logic [OS_W-1:0]       os_cnt, os_cnt_n;
  logic                  b_clk_n, pending_n;

  logic                  apply;
  logic [DIV_WIDTH-1:0]  sel_int, eff_use;
  logic [FRAC_WIDTH-1:0] sel_frac;
  logic [FRAC_WIDTH:0]   frac_sum;
  logic [CNT_W-1:0]      cnt_base;

  // Integer divisors below 2 would make os_tick continuous.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] d);
    return (d < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : d;
  endfunction

  assign os_tick  = en & (cnt == '0) & ~sync & ~rst;
  assign bit_tick = os_tick & (os_cnt == OS_W'(OVERSAMPLE - 1));

  // A load in the boundary cycle itself bypasses the shadow.
  assign apply    = div_load | div_pending;
  assign sel_int  = div_load ? div_int  : shadow_int;
  assign sel_frac = div_load ? div_frac : shadow_frac;
  assign eff_use  = apply ? clamp_div(sel_int) : clamp_div(active_int);
  assign cnt_base = CNT_W'(eff_use) - CNT_W'(1);
  assign frac_sum = {1'b0, frac_acc} + {1'b0, active_frac};

  always_comb begin
    cnt_n         = cnt;
    active_int_n  = active_int;
    active_frac_n = active_frac;
    shadow_int_n  = shadow_int;
    shadow_frac_n = shadow_frac;
    frac_acc_n    = frac_acc;
    os_cnt_n      = os_cnt;
    b_clk_n       = B_clk;
    pending_n     = div_pending;

    if (div_load) begin
      shadow_int_n  = div_int;
      shadow_frac_n = div_frac;
      pending_n     = 1'b1;
    end

    if (en) begin
      if (apply && (sync || cnt == '0)) begin
        active_int_n  = sel_int;
        active_frac_n = sel_frac;
        pending_n     = 1'b0;
      end
      if (sync) begin
        cnt_n      = cnt_base;
        os_cnt_n   = '0;
        frac_acc_n = '0;
        b_clk_n    = 1'b0;
      end else if (cnt == '0) begin
        if (apply) begin
          cnt_n      = cnt_base;
          frac_acc_n = '0;
        end else begin
          cnt_n      = cnt_base + CNT_W'(frac_sum[FRAC_WIDTH]);
          frac_acc_n = frac_sum[FRAC_WIDTH-1:0];
        end
        os_cnt_n = os_cnt + OS_W'(1);
        b_clk_n  = ~B_clk;
      end else begin
        cnt_n = cnt - CNT_W'(1);
      end
    end else if (div_pending) begin
      // Counting is frozen, so the boundary is "now"; a same-cycle load stays pending.
      active_int_n  = shadow_int;
      active_frac_n = shadow_frac;
      frac_acc_n    = '0;
      pending_n     = div_load;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= CNT_W'(DEFAULT_DIV_INT - 1);
      active_int  <= DIV_WIDTH'(DEFAULT_DIV_INT);
      active_frac <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      shadow_int  <= DIV_WIDTH'(DEFAULT_DIV_INT);
      shadow_frac <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
      frac_acc    <= '0;
      os_cnt      <= '0;
      B_clk       <= 1'b0;
      div_pending <= 1'b0;
    end else begin
      cnt         <= cnt_n;
      active_int  <= active_int_n;
      active_frac <= active_frac_n;
      shadow_int  <= shadow_int_n;
      shadow_frac <= shadow_frac_n;
      frac_acc    <= frac_acc_n;
      os_cnt      <= os_cnt_n;
      B_clk       <= b_clk_n;
      div_pending <= pending_n;
    end
  end

endmodule
